// File: rtl/ser32b_8b_buf.sv
// ser32b_8b_buf: 4-word input FIFO feeding a 32b->8b serializer.
// Bytes leave most-significant first; sof_out flags byte 0 of each word.
// Optional macro SER_IDLE_K_EN: the idle byte is K28.5 (8'hBC) instead of 8'h00.
module ser32b_8b_buf (
  input  logic        clock4,
  input  logic        reset_L,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        sof_out,
  output logic        overflow_err
);

`ifdef SER_IDLE_K_EN
  localparam logic [7:0] IDLE_BYTE = 8'hBC;
`else
  localparam logic [7:0] IDLE_BYTE = 8'h00;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  // FIFO storage and control
  logic [31:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        push;
  logic        pop;
  logic [31:0] head;

  // Serializer state
  state_t      state;
  state_t      state_nxt;
  logic [31:0] shift_q;
  logic [31:0] shift_nxt;
  logic [1:0]  idx;
  logic [1:0]  idx_nxt;
  logic [7:0]  data_nxt;
  logic        valid_nxt;
  logic        sof_nxt;

  assign ready_out = (count != 3'd4);
  assign push      = valid_in & ready_out;
  assign head      = mem[rd_ptr];

  // FIFO storage: data only, never reset; flushing is done by clearing the pointers
  always_ff @(posedge clock4) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clock4 or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr       <= 2'd0;
      rd_ptr       <= 2'd0;
      count        <= 3'd0;
      overflow_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (valid_in && !ready_out) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // Serializer next-state and next-output decode; a pop happens whenever the
  // link would otherwise go idle or the last byte of a word is on the wire
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    shift_nxt = shift_q;
    data_nxt  = IDLE_BYTE;
    valid_nxt = 1'b0;
    sof_nxt   = 1'b0;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != 3'd0) begin
          pop       = 1'b1;
          shift_nxt = {head[23:0], 8'h00};
          data_nxt  = head[31:24];
          valid_nxt = 1'b1;
          sof_nxt   = 1'b1;
          idx_nxt   = 2'd0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (idx != 2'd3) begin
          shift_nxt = {shift_q[23:0], 8'h00};
          data_nxt  = shift_q[31:24];
          valid_nxt = 1'b1;
          idx_nxt   = idx + 2'd1;
        end else if (count != 3'd0) begin
          // back-to-back: next word's byte 0 follows with no bubble
          pop       = 1'b1;
          shift_nxt = {head[23:0], 8'h00};
          data_nxt  = head[31:24];
          valid_nxt = 1'b1;
          sof_nxt   = 1'b1;
          idx_nxt   = 2'd0;
        end else begin
          idx_nxt   = 2'd0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Serializer state and registered link outputs
  always_ff @(posedge clock4 or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      idx       <= 2'd0;
      data_out  <= IDLE_BYTE;
      valid_out <= 1'b0;
      sof_out   <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
      sof_out   <= sof_nxt;
    end
  end

  // Shift register holds payload only; its contents are ignored outside SEND
  always_ff @(posedge clock4) begin
    shift_q <= shift_nxt;
  end

endmodule

// File: tb/tb_ser32b_8b_buf.sv
// tb_ser32b_8b_buf: directed and random stimulus against a queue-based
// reference model of ser32b_8b_buf, plus a byte-to-word reassembler on the link.
module tb_ser32b_8b_buf;

`ifdef SER_IDLE_K_EN
  localparam logic [7:0] IDLE_V = 8'hBC;
`else
  localparam logic [7:0] IDLE_V = 8'h00;
`endif

  logic        clock4 = 1'b0;
  logic        reset_L;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        sof_out;
  logic        overflow_err;

  int errors = 0;
  int checks = 0;

  // reference model: words waiting in the FIFO, bytes still to send of the current word
  logic [31:0] mq[$];
  logic [7:0]  cur[$];
  logic [7:0]  e_data;
  logic        e_valid;
  logic        e_sof;
  logic        e_ovf;
  logic [31:0] acc_q[$];

  // link-side capture (downstream 8b->32b reassembly)
  logic [7:0]  got[$];
  logic        got_sof[$];
  logic [7:0]  rx_bytes[$];
  logic [31:0] rx_words[$];

  always #5 clock4 = ~clock4;

  ser32b_8b_buf dut (
    .clock4       (clock4),
    .reset_L      (reset_L),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .sof_out      (sof_out),
    .overflow_err (overflow_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    cur.delete();
    e_data  = IDLE_V;
    e_valid = 1'b0;
    e_sof   = 1'b0;
    e_ovf   = 1'b0;
  endtask

  // one clock edge of the reference model, using the inputs held before the edge
  task automatic model_edge();
    logic        rdy;
    logic [31:0] w;
    rdy = (mq.size() != 4);
    if (cur.size() == 0 && mq.size() > 0) begin
      w = mq.pop_front();
      e_data  = w[31:24];
      e_valid = 1'b1;
      e_sof   = 1'b1;
      cur.push_back(w[23:16]);
      cur.push_back(w[15:8]);
      cur.push_back(w[7:0]);
    end else if (cur.size() > 0) begin
      e_data  = cur.pop_front();
      e_valid = 1'b1;
      e_sof   = 1'b0;
    end else begin
      e_data  = IDLE_V;
      e_valid = 1'b0;
      e_sof   = 1'b0;
    end
    if (valid_in) begin
      if (rdy) begin
        mq.push_back(data_in);
        acc_q.push_back(data_in);
      end else begin
        e_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".data_out"},  data_out,     e_data);
    chk({tag, ".valid_out"}, valid_out,    e_valid);
    chk({tag, ".sof_out"},   sof_out,      e_sof);
    chk({tag, ".overflow"},  overflow_err, e_ovf);
    chk({tag, ".ready_out"}, ready_out,    (mq.size() != 4));
  endtask

  task automatic step(input string tag);
    @(posedge clock4);
    model_edge();
    #1;
    check_outputs(tag);
    if (valid_out === 1'b1) begin
      got.push_back(data_out);
      got_sof.push_back(sof_out);
      if (sof_out) rx_bytes.delete();
      rx_bytes.push_back(data_out);
      if (rx_bytes.size() == 4)
        rx_words.push_back({rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]});
    end
  endtask

  initial begin
    logic [7:0]  exp27 [8];
    logic [31:0] w28 [6];
    int          k;
    int          guard;
    logic        acc;

    exp27 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    w28   = '{32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 32'hDEAD0004, 32'hDEAD0005, 32'hDEAD0006};

    // reset state
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 32'h0;
    model_reset();
    #12;
    chk("rst.data_out", data_out, IDLE_V);
    chk("rst.valid_out", valid_out, 1'b0);
    chk("rst.sof_out", sof_out, 1'b0);
    chk("rst.overflow", overflow_err, 1'b0);
    chk("rst.ready_out", ready_out, 1'b1);
    reset_L = 1'b1;

    // single word, pushed at the first edge after reset release
    valid_in = 1'b1;
    data_in  = 32'hA1B2C3D4;
    step("w26.push");
    valid_in = 1'b0;
    step("w26.b0");
    chk("w26.b0", data_out, 8'hA1); chk("w26.sof0", sof_out, 1'b1);
    step("w26.b1");
    chk("w26.b1", data_out, 8'hB2); chk("w26.sof1", sof_out, 1'b0);
    step("w26.b2");
    chk("w26.b2", data_out, 8'hC3);
    step("w26.b3");
    chk("w26.b3", data_out, 8'hD4); chk("w26.v3", valid_out, 1'b1);
    step("w26.end");
    chk("w26.idle", valid_out, 1'b0);

    // two words back to back
    got.delete(); got_sof.delete();
    valid_in = 1'b1; data_in = 32'h11223344;
    step("w27.p0");
    data_in = 32'h55667788;
    step("w27.p1");
    valid_in = 1'b0;
    for (int i = 0; i < 10; i++) step("w27.drain");
    chk("w27.count", got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("w27.byte", (i < got.size()) ? {24'h0, got[i]} : 32'hFFFFFFFF, exp27[i]);
      chk("w27.sof", (i < got_sof.size()) ? {31'h0, got_sof[i]} : 32'hFFFFFFFF, (i == 0 || i == 4));
    end

    // six consecutive pushes: FIFO fills, sixth word dropped
    rx_words.delete();
    valid_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_in = w28[i];
      step("w28.push");
      if (i == 4) chk("w28.full", ready_out, 1'b0);
    end
    chk("w28.ovf", overflow_err, 1'b1);
    valid_in = 1'b0;
    for (int i = 0; i < 24; i++) step("w28.drain");
    chk("w28.nwords", rx_words.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("w28.word", (i < rx_words.size()) ? rx_words[i] : 32'hFFFFFFFF, w28[i]);

    // reset in the middle of a word
    valid_in = 1'b1; data_in = 32'hA1B2C3D4;
    step("w29.push");
    valid_in = 1'b0;
    step("w29.b0");
    step("w29.b1");
    chk("w29.b1", data_out, 8'hB2);
    #2;
    reset_L = 1'b0;
    model_reset();
    #1;
    chk("w29.rst.data_out", data_out, IDLE_V);
    chk("w29.rst.valid_out", valid_out, 1'b0);
    chk("w29.rst.sof_out", sof_out, 1'b0);
    chk("w29.rst.overflow", overflow_err, 1'b0);
    chk("w29.rst.ready_out", ready_out, 1'b1);
    @(negedge clock4);
    reset_L = 1'b1;
    for (int i = 0; i < 6; i++) step("w29.after");

    // idle with no pushes
    for (int i = 0; i < 4; i++) begin
      step("w30.idle");
      chk("w30.data", data_out, IDLE_V);
      chk("w30.valid", valid_out, 1'b0);
    end

    // loopback of 1..16 with flow control from the model's view of space
    acc_q.delete(); rx_words.delete();
    k = 1;
    guard = 0;
    while (k <= 16 && guard < 200) begin
      valid_in = 1'b1;
      data_in  = k;
      acc = (mq.size() != 4);
      step("w31.push");
      if (acc) k++;
      guard++;
    end
    chk("w31.bound", guard < 200, 1'b1);
    valid_in = 1'b0;
    for (int i = 0; i < 24; i++) step("w31.drain");
    chk("w31.nwords", rx_words.size(), 16);
    for (int i = 0; i < 16; i++)
      chk("w31.word", (i < rx_words.size()) ? rx_words[i] : 32'hFFFFFFFF, i + 1);

    // random traffic against the model, then order/integrity of what came out
    acc_q.delete(); rx_words.delete();
    for (int i = 0; i < 300; i++) begin
      valid_in = 1'($urandom_range(0, 1));
      data_in  = $urandom;
      step("rnd");
    end
    valid_in = 1'b0;
    for (int i = 0; i < 24; i++) step("rnd.drain");
    chk("rnd.nwords", rx_words.size(), acc_q.size());
    for (int i = 0; i < acc_q.size(); i++)
      chk("rnd.word", (i < rx_words.size()) ? rx_words[i] : ~acc_q[i], acc_q[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
